// File: rtl/key_repeat.sv
// Per-key press-event generator with delayed auto-shift and auto-repeat.
// Sits after the debouncers; emits one-cycle registered key events.
module key_repeat #(
  parameter int                N_KEYS      = 4,
  parameter int                DAS_CYC     = 20_000_000,
  parameter int                ARR_CYC     = 5_000_000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK = 4'b0111
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_KEYS-1:0]                       key_enabled,
  output logic [N_KEYS-1:0]                       key_pulse,
  output logic                                    key_valid,
  output logic [((N_KEYS > 1) ? $clog2(N_KEYS) : 1)-1:0] key_code
);

  localparam int CW    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int MAXC  = (DAS_CYC > ARR_CYC) ? DAS_CYC : ARR_CYC;
  localparam int CNT_W = $clog2(MAXC);

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYC - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } state_t;

  state_t           state_r     [N_KEYS];
  state_t           state_nxt_s [N_KEYS];
  logic [CNT_W-1:0] cnt_r       [N_KEYS];
  logic [CNT_W-1:0] cnt_nxt_s   [N_KEYS];

  logic [N_KEYS-1:0] key_q_r;
  logic [N_KEYS-1:0] rise_s;
  logic [N_KEYS-1:0] pulse_nxt_s;
  logic [N_KEYS-1:0] pulse_r;
  logic              valid_r;
  logic [CW-1:0]     code_r;
  logic [CW-1:0]     code_nxt_s;

  assign rise_s = key_enabled & ~key_q_r;

  // Per-key FSM next state, counter update and event generation
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      pulse_nxt_s[i] = 1'b0;
      case (state_r[i])
        IDLE: begin
          if (rise_s[i]) begin
            pulse_nxt_s[i] = 1'b1;
            cnt_nxt_s[i]   = {CNT_W{1'b0}};
            state_nxt_s[i] = REPEAT_MASK[i] ? DELAY : HELD;
          end else begin
            state_nxt_s[i] = IDLE;
          end
        end
        DELAY: begin
          // Release takes priority over a repeat due on the same edge
          if (!key_enabled[i]) begin
            state_nxt_s[i] = IDLE;
            cnt_nxt_s[i]   = {CNT_W{1'b0}};
          end else if (cnt_r[i] == DAS_LAST) begin
            pulse_nxt_s[i] = 1'b1;
            cnt_nxt_s[i]   = {CNT_W{1'b0}};
            state_nxt_s[i] = REPEAT;
          end else begin
            cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!key_enabled[i]) begin
            state_nxt_s[i] = IDLE;
            cnt_nxt_s[i]   = {CNT_W{1'b0}};
          end else if (cnt_r[i] == ARR_LAST) begin
            pulse_nxt_s[i] = 1'b1;
            cnt_nxt_s[i]   = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (!key_enabled[i]) begin
            state_nxt_s[i] = IDLE;
          end else begin
            state_nxt_s[i] = HELD;
          end
        end
        default: begin
          state_nxt_s[i] = IDLE;
          cnt_nxt_s[i]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Lowest-numbered pulsing key wins the code
  always_comb begin
    code_nxt_s = {CW{1'b0}};
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pulse_nxt_s[i]) begin
        code_nxt_s = CW'(i);
      end else begin
        code_nxt_s = code_nxt_s;
      end
    end
  end

  // State, counters, input copy and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q_r <= {N_KEYS{1'b1}};
      pulse_r <= {N_KEYS{1'b0}};
      valid_r <= 1'b0;
      code_r  <= {CW{1'b0}};
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= {CNT_W{1'b0}};
      end
    end else begin
      key_q_r <= key_enabled;
      pulse_r <= pulse_nxt_s;
      valid_r <= |pulse_nxt_s;
      code_r  <= code_nxt_s;
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
    end
  end

  assign key_pulse = pulse_r;
  assign key_valid = valid_r;
  assign key_code  = code_r;

endmodule

// File: tb/tb_key_repeat.sv
// Self-checking bench for key_repeat: directed scenarios plus random key
// activity, compared against a press-time based reference model.
module tb_key_repeat;

  localparam int DAS = 8;
  localparam int ARR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_enabled = 4'b0000;
  logic [3:0] key_pulse;
  logic       key_valid;
  logic [1:0] key_code;

  int total = 0;
  int bad   = 0;

  // reference model: each active key remembers the edge of its press
  int         ecyc = 0;
  int         tpress [4];
  bit         active [4];
  logic [3:0] prev = 4'b1111;
  logic [3:0] exp_pulse = 4'b0000;
  logic       exp_valid = 1'b0;
  logic [1:0] exp_code = 2'd0;
  int         obs_cnt [4];

  key_repeat #(
    .N_KEYS(4), .DAS_CYC(DAS), .ARR_CYC(ARR), .REPEAT_MASK(4'b0111)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_enabled(key_enabled),
    .key_pulse(key_pulse), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic [3:0] k, input logic r);
    int d;
    exp_pulse = 4'b0000;
    if (!r) begin
      for (int i = 0; i < 4; i++) active[i] = 1'b0;
      prev = 4'b1111;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (active[i]) begin
          if (!k[i]) begin
            active[i] = 1'b0;
          end else if (i != 3) begin
            d = ecyc - tpress[i];
            if (d == DAS || (d > DAS && ((d - DAS) % ARR) == 0))
              exp_pulse[i] = 1'b1;
          end
        end else if (k[i] && !prev[i]) begin
          active[i]    = 1'b1;
          tpress[i]    = ecyc;
          exp_pulse[i] = 1'b1;
        end
      end
      prev = k;
    end
    exp_valid = |exp_pulse;
    exp_code  = 2'd0;
    for (int i = 3; i >= 0; i--) if (exp_pulse[i]) exp_code = 2'(i);
    ecyc++;
  endtask

  task automatic step(input logic [3:0] k, input logic r);
    @(negedge clk);
    key_enabled = k;
    rst_n       = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
    total++;
    assert (key_pulse === exp_pulse) else begin
      bad++;
      $error("FAIL pulse cyc=%0d obs=%b exp=%b", ecyc, key_pulse, exp_pulse);
    end
    total++;
    assert (key_valid === exp_valid) else begin
      bad++;
      $error("FAIL valid cyc=%0d obs=%b exp=%b", ecyc, key_valid, exp_valid);
    end
    total++;
    assert (key_code === exp_code) else begin
      bad++;
      $error("FAIL code cyc=%0d obs=%0d exp=%0d", ecyc, key_code, exp_code);
    end
    for (int i = 0; i < 4; i++) if (key_pulse[i] === 1'b1) obs_cnt[i]++;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 4; i++) obs_cnt[i] = 0;
  endtask

  task automatic check_cnt(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] k;
    logic       r;
    for (int i = 0; i < 4; i++) begin
      tpress[i] = 0;
      active[i] = 1'b0;
    end
    clr_cnt();

    // 1: key 0 held through reset release produces nothing until re-press
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
    check_cnt("reset_outputs", int'({key_pulse, key_valid, key_code}), 0);
    clr_cnt();
    for (int i = 0; i < 20; i++) step(4'b0001, 1'b1);
    check_cnt("held_at_reset", obs_cnt[0], 0);
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    check_cnt("repress_pulse", int'(key_pulse[0]), 1);
    step(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);

    // 2: key 1 held 20 edges -> press, DAS, then three ARR repeats
    clr_cnt();
    for (int i = 0; i < 20; i++) begin
      step(4'b0010, 1'b1);
      if (key_valid === 1'b1) check_cnt("k1_code", int'(key_code), 1);
    end
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);
    check_cnt("k1_repeats", obs_cnt[1], 5);

    // 3: non-repeat key 3 fires once
    clr_cnt();
    for (int i = 0; i < 40; i++) step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    check_cnt("k3_once", obs_cnt[3], 1);

    // 4: release on the edge the first repeat would fire
    clr_cnt();
    for (int i = 0; i < DAS; i++) step(4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b1);
    check_cnt("k0_release_wins", obs_cnt[0], 1);

    // 5: simultaneous rises on keys 1 and 2
    step(4'b0110, 1'b1);
    check_cnt("simul_pulse", int'(key_pulse), 6);
    check_cnt("simul_code", int'(key_code), 1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // 6: reset mid-repeat with key 0 still held
    for (int i = 0; i < 12; i++) step(4'b0001, 1'b1);
    clr_cnt();
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    for (int i = 0; i < 12; i++) step(4'b0001, 1'b1);
    check_cnt("reset_abort", obs_cnt[0], 0);
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    check_cnt("after_abort_press", int'(key_pulse[0]), 1);
    step(4'b0000, 1'b1);

    // random key activity with occasional resets
    k = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 13) == 0) k[i] = ~k[i];
      r = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step(k, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
